// File: rtl/morse_key_classifier.sv
// Morse straight-key front end: synchronises and debounces the raw key, times marks and gaps
// in Morse units and emits one-hot dot/dash/char-space/word-space pulses with holdoff windows.
module morse_key_classifier #(
    parameter int unsigned UNIT_CYC     = 4,
    parameter int unsigned DEBOUNCE_CYC = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic dot_inp,
    output logic dash_inp,
    output logic char_space_inp,
    output logic word_space_inp
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DASH_TH = CNT_W'(2 * UNIT_CYC);
    localparam logic [CNT_W-1:0] CHAR_TH = CNT_W'(3 * UNIT_CYC);
    localparam logic [CNT_W-1:0] WORD_TH = CNT_W'(7 * UNIT_CYC);

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StGap,
        StGapC
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [1:0]       sync_q;
    logic             key_s;
    logic             key_db_q, key_db_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]       hold_q, hold_d;
    logic             pend_q, pend_d;
    logic             pend_dash_q, pend_dash_d;
    logic             dot_q, dot_d;
    logic             dash_q, dash_d;
    logic             char_q, char_d;
    logic             word_q, word_d;

    logic sym_req, sym_dash, char_req, word_req;

    assign key_s = sync_q[1];

    // Debounce: adopt key_s only after it has disagreed for DEBOUNCE_CYC consecutive samples.
    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (key_s != key_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_db_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Mark/gap timing FSM; a key rise in a gap always wins over a space threshold.
    always_comb begin
        state_d    = state_q;
        mark_cnt_d = mark_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sym_req    = 1'b0;
        sym_dash   = 1'b0;
        char_req   = 1'b0;
        word_req   = 1'b0;
        case (state_q)
            StIdle: begin
                if (key_db_q) begin
                    state_d    = StMark;
                    mark_cnt_d = CNT_W'(1);
                end
            end
            StMark: begin
                if (key_db_q) begin
                    mark_cnt_d = sat_inc(mark_cnt_q);
                end else begin
                    sym_req   = 1'b1;
                    sym_dash  = (mark_cnt_q >= DASH_TH);
                    gap_cnt_d = CNT_W'(1);
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (key_db_q) begin
                    state_d    = StMark;
                    mark_cnt_d = CNT_W'(1);
                end else begin
                    gap_cnt_d = sat_inc(gap_cnt_q);
                    if (gap_cnt_q == CHAR_TH) begin
                        char_req = 1'b1;
                        state_d  = StGapC;
                    end
                end
            end
            StGapC: begin
                if (key_db_q) begin
                    state_d    = StMark;
                    mark_cnt_d = CNT_W'(1);
                end else begin
                    gap_cnt_d = sat_inc(gap_cnt_q);
                    if (gap_cnt_q == WORD_TH) begin
                        word_req = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output stage: spaces start a holdoff; symbols landing inside one wait in the pending slot.
    always_comb begin
        dot_d       = 1'b0;
        dash_d      = 1'b0;
        char_d      = 1'b0;
        word_d      = 1'b0;
        hold_d      = hold_q;
        pend_d      = pend_q;
        pend_dash_d = pend_dash_q;

        if (char_req) begin
            char_d = 1'b1;
            hold_d = 3'd3;
        end else if (word_req) begin
            word_d = 1'b1;
            hold_d = 3'd7;
        end else if (hold_q != 3'd0) begin
            hold_d = hold_q - 3'd1;
        end

        if (sym_req) begin
            if (char_req || word_req || (hold_q != 3'd0)) begin
                pend_d      = 1'b1;
                pend_dash_d = sym_dash;
            end else begin
                dot_d  = ~sym_dash;
                dash_d = sym_dash;
            end
        end else if (pend_q && (hold_q == 3'd0) && !char_req && !word_req) begin
            dot_d  = ~pend_dash_q;
            dash_d = pend_dash_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q      <= '0;
            key_db_q    <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= StIdle;
            mark_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            pend_dash_q <= 1'b0;
            dot_q       <= 1'b0;
            dash_q      <= 1'b0;
            char_q      <= 1'b0;
            word_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_in};
            key_db_q    <= key_db_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            mark_cnt_q  <= mark_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            pend_dash_q <= pend_dash_d;
            dot_q       <= dot_d;
            dash_q      <= dash_d;
            char_q      <= char_d;
            word_q      <= word_d;
        end
    end

    assign dot_inp        = dot_q;
    assign dash_inp       = dash_q;
    assign char_space_inp = char_q;
    assign word_space_inp = word_q;

endmodule

// File: doc/morse_key_classifier.md
# morse_key_classifier

Front-end timing classifier that sits directly upstream of the Morse decoder. It samples a single raw straight-key line, synchronises and debounces it, and measures mark and gap durations in Morse units. It emits one-cycle `dot_inp` / `dash_inp` / `char_space_inp` / `word_space_inp` pulses. The pulse stream obeys the decoder's input rules: at most one pulse high per cycle, and mandatory quiet windows after space pulses.

## Interface
- `UNIT_CYC`, 4: clock cycles per Morse unit; legal range ≥ 2.
- `DEBOUNCE_CYC`, 2: consecutive stable synchronised samples required before the debounced key changes; legal range ≥ 1.
- `CNT_W`, 16: width of the mark and gap cycle counters; both saturate at all-ones.

- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst` input 1: reset, synchronous and active-low (0 = reset).
- `key_in` input 1: raw key, asynchronous to `clk`, 1 = key down.
- `dot_inp` output 1: one-cycle dot pulse.
- `dash_inp` output 1: one-cycle dash pulse.
- `char_space_inp` output 1: one-cycle inter-character gap pulse.
- `word_space_inp` output 1: one-cycle inter-word gap pulse.

## Operation
- **Input conditioning**
  - `key_in` passes through a 2-flop synchroniser to give `key_s`.
  - The debouncer holds `key_db`. `key_db` takes the value of `key_s` only after `key_s` has differed from `key_db` for `DEBOUNCE_CYC` consecutive cycles.
  - `key_db` resets to 0.
- **FSM states:** IDLE, MARK, GAP, GAP_C.
  - IDLE (reset state): `key_db`=1 → MARK, mark counter = 1.
  - MARK: the mark counter increments on each cycle with `key_db`=1.
  - MARK, `key_db` falls: classify the mark, then → GAP with gap counter = 1.
    - Dash iff mark count ≥ 2·`UNIT_CYC`; otherwise dot.
  - GAP: the gap counter increments on each cycle with `key_db`=0.
  - GAP, count reaches 3·`UNIT_CYC`: request `char_space_inp`, → GAP_C.
  - GAP_C, count reaches 7·`UNIT_CYC`: request `word_space_inp`, → IDLE.
  - GAP or GAP_C, `key_db`=1: → MARK, mark counter = 1, gap count discarded.
    - A gap shorter than 3 units is intra-character and produces no space pulse.
- No space pulses are produced after reset until the first mark. IDLE never produces pulses.
- **Holdoff**
  - After `char_space_inp`, no output may be asserted for the following 3 cycles.
  - After `word_space_inp`, no output may be asserted for the following 7 cycles.
  - A dot/dash classified during a holdoff is held in a 1-deep pending register. It is emitted in the first cycle after the holdoff expires.
  - Only one symbol can be pending; the mark/debounce timing guarantees this.
- **Outputs**
  - All outputs are registered.
  - At most one output is high in any cycle.
  - A space request never coincides with a symbol emission, because `UNIT_CYC` ≥ 2.

## Timing
- Reset: the cycle after `rst` is sampled 0, all four outputs are 0. At the same edge, the FSM goes to IDLE and the counters, pending register, holdoff counter, synchroniser and `key_db` are cleared.
- Reset asserted mid-mark or mid-gap discards the symbol in progress; nothing is emitted.
- `key_in` to `key_db` latency is 2 + `DEBOUNCE_CYC` cycles.
- Symbol pulse: high for exactly 1 cycle, in the cycle after `key_db` is first seen 0 (gap cycle 1 registered). Holdoff can defer it.
- `char_space_inp`: high 1 cycle, 3·`UNIT_CYC` cycles after the symbol pulse's reference edge, provided `key_db` stayed 0 throughout.
- `word_space_inp`: high 1 cycle, at 7·`UNIT_CYC` on the same reference, under the same condition.
- Counter saturation: a mark longer than 2^`CNT_W`−1 cycles is still classified as a dash.
- `key_db` rising in the same cycle the gap count reaches the 3·`UNIT_CYC` or 7·`UNIT_CYC` threshold: the rise wins, and no space pulse is emitted.

## Test plan
- **Reset:** `rst`=0 for 3 cycles while `key_in` toggles, then `key_in`=0 for 60 cycles → all outputs 0 throughout; no spaces emitted from IDLE.
- **Dot and spaces** (`UNIT_CYC`=4, `DEBOUNCE_CYC`=2): `key_db` high 4 cycles, then low → one `dot_inp` pulse.
  - `char_space_inp` follows 12 cycles after the `key_db` fall.
  - `word_space_inp` follows at 28 cycles.
  - Exactly one pulse of each.
- **Dot/dash boundary:** mark of 7 cycles → `dot_inp`; mark of 8 cycles → `dash_inp`; mark of 70000 cycles (saturation) → `dash_inp`.
- **Intra-character gap:** dot, then an 8-cycle gap, then a 10-cycle mark → `dot_inp` then `dash_inp`, with no `char_space_inp` between them. `char_space_inp` follows 12 cycles after the dash's `key_db` fall.
- **Glitch rejection:** `key_in` high for 1 cycle → `key_db` never rises, and no outputs for 60 cycles.
- **Word holdoff:** `key_db` rises in gap cycle 29 (1 cycle after `word_space_inp`) with a 2-cycle mark.
  - Required: the dot is classified inside the 7-cycle holdoff and is emitted exactly 8 cycles after `word_space_inp`.
  - Required: nothing is emitted earlier.
  - The one-hot check holds on every cycle.
